// File: rtl/gyruss_psg_arb.sv
// gyruss_psg_arb: round-robin arbiter that sequences two requesters onto a shared bank of AY-style PSGs.
// Define PSG_ARB_READBACK_EN to enable R0 register reads (READ state and live R0_RDATA).
module gyruss_psg_arb #(
  parameter int HOLD  = 2,
  parameter int NCHIP = 5
) (
  input  logic             MCLK,
  input  logic             RESET_N,
  input  logic             R0_REQ,
  input  logic             R0_WR,
  input  logic [2:0]       R0_CHIP,
  input  logic [3:0]       R0_REG,
  input  logic [7:0]       R0_DATA,
  output logic             R0_ACK,
  output logic [7:0]       R0_RDATA,
  input  logic             R1_REQ,
  input  logic [2:0]       R1_CHIP,
  input  logic [3:0]       R1_REG,
  input  logic [7:0]       R1_DATA,
  output logic             R1_ACK,
  output logic [NCHIP-1:0] PSG_BDIR,
  output logic [NCHIP-1:0] PSG_BC1,
  output logic [7:0]       PSG_DO,
  input  logic [7:0]       PSG_DI,
  output logic [2:0]       PSG_SEL,
  output logic             BUSY
);

  localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);
  localparam logic [3:0] NCHIP_L   = 4'(NCHIP);

`ifdef PSG_ARB_READBACK_EN
  typedef enum logic [2:0] {IDLE, LATCH, GAP, WRITE, READ, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, LATCH, GAP, WRITE, DONE} state_t;
`endif

  state_t           state, state_nx;
  logic [3:0]       cnt, cnt_nx;
  logic             gnt_r1, gnt_r1_nx;
  logic [2:0]       chip_nx;
  logic [3:0]       cur_reg, reg_nx;
  logic [7:0]       cur_data, data_nx;
  logic             phase_end;
  logic [NCHIP-1:0] chip_hot;
  logic [NCHIP-1:0] bdir_nx, bc1_nx;
  logic [7:0]       do_nx;
  logic             ack0_nx, ack1_nx;

`ifdef PSG_ARB_READBACK_EN
  logic cur_wr, wr_nx;
  logic cur_chip_ok;
`else
  logic unused_rd;
  assign unused_rd = ^{R0_WR, PSG_DI};
`endif

  assign phase_end = (cnt == HOLD_LAST);
  assign BUSY      = (state != IDLE);

  // gnt_r1 doubles as the round-robin pointer: it names whoever was granted last
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    gnt_r1_nx = gnt_r1;
    chip_nx   = PSG_SEL;
    reg_nx    = cur_reg;
    data_nx   = cur_data;
`ifdef PSG_ARB_READBACK_EN
    wr_nx     = cur_wr;
`endif
    case (state)
      IDLE: begin
        if (R0_REQ || R1_REQ) begin
          state_nx  = LATCH;
          cnt_nx    = 4'd0;
          gnt_r1_nx = R1_REQ && (!R0_REQ || !gnt_r1);
          if (gnt_r1_nx) begin
            chip_nx = R1_CHIP;
            reg_nx  = R1_REG;
            data_nx = R1_DATA;
`ifdef PSG_ARB_READBACK_EN
            wr_nx   = 1'b1;
`endif
          end else begin
            chip_nx = R0_CHIP;
            reg_nx  = R0_REG;
            data_nx = R0_DATA;
`ifdef PSG_ARB_READBACK_EN
            wr_nx   = R0_WR;
`endif
          end
        end
      end
      LATCH: begin
        if (phase_end) begin
          state_nx = GAP;
          cnt_nx   = 4'd0;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      GAP: begin
        cnt_nx = 4'd0;
`ifdef PSG_ARB_READBACK_EN
        state_nx = cur_wr ? WRITE : READ;
`else
        state_nx = WRITE;
`endif
      end
      WRITE: begin
        if (phase_end) begin
          state_nx = DONE;
          cnt_nx   = 4'd0;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
`ifdef PSG_ARB_READBACK_EN
      READ: begin
        if (phase_end) begin
          state_nx = DONE;
          cnt_nx   = 4'd0;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
`endif
      DONE: begin
        state_nx = IDLE;
        cnt_nx   = 4'd0;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = 4'd0;
      end
    endcase
  end

  // Out-of-range chip indices decode to no strobe at all
  always_comb begin
    chip_hot = '0;
    for (int i = 0; i < NCHIP; i++) begin
      chip_hot[i] = ({1'b0, chip_nx} < NCHIP_L) && (chip_nx == 3'(i));
    end
  end

  // Bus outputs are decoded from the next state so they register in step with it
  always_comb begin
    bdir_nx = '0;
    bc1_nx  = '0;
    do_nx   = PSG_DO;
    ack0_nx = 1'b0;
    ack1_nx = 1'b0;
    case (state_nx)
      LATCH: begin
        bdir_nx = chip_hot;
        bc1_nx  = chip_hot;
        do_nx   = {4'h0, reg_nx};
      end
      WRITE: begin
        bdir_nx = chip_hot;
        do_nx   = data_nx;
      end
`ifdef PSG_ARB_READBACK_EN
      READ: begin
        bc1_nx = chip_hot;
      end
`endif
      DONE: begin
        ack0_nx = !gnt_r1_nx;
        ack1_nx = gnt_r1_nx;
      end
      default: begin
        bdir_nx = '0;
      end
    endcase
  end

  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      gnt_r1   <= 1'b1;
      PSG_SEL  <= 3'd0;
      cur_reg  <= 4'd0;
      cur_data <= 8'd0;
      PSG_BDIR <= '0;
      PSG_BC1  <= '0;
      PSG_DO   <= 8'd0;
      R0_ACK   <= 1'b0;
      R1_ACK   <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      gnt_r1   <= gnt_r1_nx;
      PSG_SEL  <= chip_nx;
      cur_reg  <= reg_nx;
      cur_data <= data_nx;
      PSG_BDIR <= bdir_nx;
      PSG_BC1  <= bc1_nx;
      PSG_DO   <= do_nx;
      R0_ACK   <= ack0_nx;
      R1_ACK   <= ack1_nx;
    end
  end

`ifdef PSG_ARB_READBACK_EN
  assign cur_chip_ok = ({1'b0, PSG_SEL} < NCHIP_L);

  // Read data is taken on the final READ cycle; a missing chip reads as an open bus
  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cur_wr   <= 1'b1;
      R0_RDATA <= 8'd0;
    end else begin
      cur_wr <= wr_nx;
      if (state == READ && phase_end && !gnt_r1) begin
        R0_RDATA <= cur_chip_ok ? PSG_DI : 8'hFF;
      end
    end
  end
`else
  assign R0_RDATA = 8'hFF;
`endif

endmodule
